// File: rtl/mod_access_sched_if.sv
// Requester/resource bundle for the round-robin access scheduler.
// master is the scheduler side, slave is the requester/resource side.
interface mod_access_sched_if #(
  parameter int unsigned ADDR = 22,
  parameter int unsigned DATA = 5,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              rsp_err;
  logic [DATA-1:0]   rsp_data;
  logic [ADDR-4:0]   rsp_newaddr;
  logic              busy;
  logic              res_sel;
  logic [1:0]        res_addr;
  logic              res_rdy;
  logic [DATA-1:0]   res_data;
  logic [ADDR-4:0]   res_newaddr;

  modport master (
    input  req, req_addr, res_rdy, res_data, res_newaddr,
    output gnt, done, rsp_err, rsp_data, rsp_newaddr, busy, res_sel, res_addr
  );

  modport slave (
    output req, req_addr, res_rdy, res_data, res_newaddr,
    input  gnt, done, rsp_err, rsp_data, rsp_newaddr, busy, res_sel, res_addr
  );
endinterface

// File: rtl/mod_access_sched.sv
// Round-robin scheduler sharing one lookup resource among NREQ requesters,
// with a bounded wait for res_rdy and a one-cycle done pulse per transaction.
module mod_access_sched #(
  parameter int unsigned ADDR = 22,
  parameter int unsigned DATA = 5,
  parameter int unsigned WAIT = 10,
  parameter int unsigned NREQ = 4
) (
  input logic                clk,
  input logic                rst,
  mod_access_sched_if.master bus
);
  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = $clog2(WAIT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PTRW-1:0] rr_q, rr_d;
  logic [PTRW-1:0] win_q, win_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      addr_q, addr_d;
  logic            err_q, err_d;
  logic [DATA-1:0] data_q, data_d;
  logic [ADDR-4:0] newaddr_q, newaddr_d;

  logic [PTRW-1:0] pick;
  logic            pick_vld;
  logic [PTRW-1:0] idx;
  logic [NREQ-1:0] win_oh;

  // First set request at or after the rr pointer, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PTRW'((32'(rr_q) + i) % NREQ);
      if (!pick_vld && bus.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    data_d    = data_q;
    newaddr_d = newaddr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          win_d   = pick;
          addr_d  = bus.req_addr[{pick, 1'b0} +: 2];
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // A ready on the final wait cycle still counts as success.
        if (bus.res_rdy) begin
          state_d   = RESP;
          data_d    = bus.res_data;
          newaddr_d = bus.res_newaddr;
          err_d     = 1'b0;
        end else if (cnt_q == CNTW'(WAIT - 1)) begin
          state_d   = RESP;
          data_d    = '0;
          newaddr_d = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        rr_d    = (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + PTRW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      newaddr_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      data_q    <= data_d;
      newaddr_q <= newaddr_d;
    end
  end

  assign win_oh          = NREQ'(1) << win_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.res_sel     = (state_q == BUSY);
  assign bus.gnt         = (state_q != IDLE) ? win_oh : '0;
  assign bus.done        = (state_q == RESP) ? win_oh : '0;
  assign bus.res_addr    = addr_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_data    = data_q;
  assign bus.rsp_newaddr = newaddr_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.gnt));
  a_done_in_gnt: assert property (@(posedge clk) disable iff (!rst)
    (bus.done & ~bus.gnt) == '0);
endmodule
